bitwise_reduce_unit: RTL and testbench
======================================

# bitwise_reduce_unit

Parametrised, streaming successor to the fixed 2-input gate cells in the curated circuit set. It folds a packet of WIDTH-bit words through a selectable bitwise operation (AND, OR, XOR, NAND) and emits one result word per packet with a beat count. Input and output use valid/ready handshakes, so the block drops into generated training-circuit pipelines between a stimulus source and a monitor.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- CNT_W, 8, beat-counter width in bits (≥1)

- clk  input  1  single clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- op  input  2  operation: 0 AND, 1 OR, 2 XOR, 3 NAND; sampled on first beat of packet
- in_valid  input  1  input word valid
- in_ready  output  1  block accepts input word
- in_data  input  WIDTH  input word
- in_last  input  1  final word of packet
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  WIDTH  packet result
- out_count  output  CNT_W  beats in packet, saturating
- out_parity  output  1  XOR of out_data bits (only with LOGIC_REDUCE_PARITY_EN)

## Operation
- Beat accepted when in_valid && in_ready.
- States: IDLE (no packet open), ACCUM (packet open), HOLD (result presented).
- IDLE: first accepted beat latches op into op_q, loads acc = in_data, cnt = 1. If in_last → HOLD, else → ACCUM.
- ACCUM: each accepted beat: acc = acc OP in_data (NAND accumulates as AND); cnt = cnt+1, saturating at 2^CNT_W−1. in_last → HOLD.
- HOLD: out_valid=1; out_data = ~acc if op_q==NAND, else acc; out_count = cnt. On out_ready → IDLE.
- op changes while in ACCUM/HOLD are ignored; op_q governs the whole packet.
- Single-beat packet: result = in_data (or ~in_data for NAND), count 1.
- in_ready = 1 in IDLE and ACCUM, 0 in HOLD; 0 while rst is high.
- Invalid-free: in_data/in_last are don't-care when in_valid=0; no state change.

## Timing
- Reset values: in_ready 0 (during rst), out_valid 0, out_data 0, out_count 0, out_parity 0; state IDLE, acc 0, cnt 0, op_q AND. After rst deasserts, in_ready=1 in the first cycle.
- Latency: result visible (out_valid=1) the cycle after the in_last beat is accepted.
- Throughput: one beat per cycle inside a packet; minimum one idle input cycle per packet (HOLD). Back-to-back packets: next first beat accepted the cycle after the out_valid && out_ready handshake.
- out_valid, out_data, out_count stable while out_valid && !out_ready.
- rst mid-packet or mid-HOLD: open packet and pending result discarded immediately; no output emitted.
- Outputs are registered; in_ready is combinational from state and rst only (no path from out_ready).

## Configuration
- LOGIC_REDUCE_PARITY_EN defined: out_parity port present, registered with out_data, equals ^out_data, reset 0.
- Not defined: port absent; no parity logic; all other behaviour identical.

## Structure
- Package logic_reduce_pkg: op enum (OP_AND=0, OP_OR=1, OP_XOR=2, OP_NAND=3), state enum (S_IDLE, S_ACCUM, S_HOLD).
- One sub-module logic_op_slice: combinational WIDTH-bit a OP b with NAND mapped to AND; used for the acc update.
- FSM, counter, output registers in bitwise_reduce_unit.

## Test plan
- WIDTH=8, op=AND, packet 0xFF,0xF0,0x3C (last) → out_data 0x30, out_count 3, valid one cycle after last beat.
- op=XOR, packet 0x01,0x02,0x04,0x08 → 0x0F, count 4; with parity macro out_parity=0; op switched to OR mid-packet has no effect.
- op=NAND single beat 0xA5 with in_last → out_data 0x5A, count 1; op=OR packet 0x00,0x00 → 0x00.
- out_ready held 0 for 5 cycles in HOLD → outputs stable, in_ready 0 throughout; out_ready=1 → IDLE, next packet first beat accepted the following cycle.
- CNT_W=2, OR packet of 6 beats → out_count saturates at 3, out_data correct.
- rst pulsed after 2 beats of a 4-beat packet → out_valid stays 0; fresh packet 0x11 (last) after reset → 0x11, count 1.

Source files
------------

// File: rtl/logic_reduce_pkg.sv
`default_nettype none
// ============================================================================
// Module  : logic_reduce_pkg
// Brief   : Operation and state encodings shared by the bitwise reduce unit.
// Revision: 1.0 - initial release
// ============================================================================
package logic_reduce_pkg;

    localparam int c_op_w    = 2;
    localparam int c_state_w = 2;

    typedef enum logic [c_op_w-1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_NAND = 2'd3
    } op_e;

    typedef enum logic [c_state_w-1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/logic_op_slice.sv
`default_nettype none
// ============================================================================
// Module  : logic_op_slice
// Brief   : Combinational WIDTH-bit a OP b; NAND folds as AND (inverted later).
// Revision: 1.0 - initial release
// ============================================================================
module logic_op_slice
    import logic_reduce_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  op_e              i_op,
    output logic [WIDTH-1:0] o_y
);

    always_comb begin
        o_y = i_a & i_b;
        case (i_op)
            OP_OR:   o_y = i_a | i_b;
            OP_XOR:  o_y = i_a ^ i_b;
            default: o_y = i_a & i_b;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bitwise_reduce_unit.sv
`default_nettype none
// ============================================================================
// Module  : bitwise_reduce_unit
// Brief   : Streams a packet of words through AND/OR/XOR/NAND and emits one
//           result word plus saturating beat count per packet.
//           Optional out_parity port enabled by LOGIC_REDUCE_PARITY_EN.
// Revision: 1.0 - initial release
// ============================================================================
module bitwise_reduce_unit
    import logic_reduce_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count
`ifdef LOGIC_REDUCE_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    state_e           r_state;
    op_e              r_op_q;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [CNT_W-1:0] r_out_count;

    logic             w_accept;
    logic             w_first;
    op_e              w_op_eff;
    logic [WIDTH-1:0] w_fold;
    logic [WIDTH-1:0] w_acc_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [WIDTH-1:0] w_result;

    assign in_ready = !rst && (r_state != S_HOLD);
    assign w_accept = in_valid && in_ready;
    assign w_first  = (r_state == S_IDLE);
    // The first beat of a packet uses the live op; later beats use the latched one.
    assign w_op_eff = w_first ? op_e'(op) : r_op_q;

    logic_op_slice #(
        .WIDTH (WIDTH)
    ) u_slice (
        .i_a  (r_acc),
        .i_b  (in_data),
        .i_op (r_op_q),
        .o_y  (w_fold)
    );

    assign w_acc_next = w_first ? in_data : w_fold;
    assign w_cnt_next = w_first ? c_cnt_one :
                        (r_cnt == c_cnt_max) ? r_cnt : r_cnt + c_cnt_one;
    assign w_result   = (w_op_eff == OP_NAND) ? ~w_acc_next : w_acc_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op_q      <= OP_AND;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
`ifdef LOGIC_REDUCE_PARITY_EN
            out_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_acc_next;
                        r_cnt <= w_cnt_next;
                        if (w_first) begin
                            r_op_q <= op_e'(op);
                        end
                        if (in_last) begin
                            r_state     <= S_HOLD;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_result;
                            r_out_count <= w_cnt_next;
`ifdef LOGIC_REDUCE_PARITY_EN
                            out_parity  <= ^w_result;
`endif
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_bitwise_reduce_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_bitwise_reduce_unit
// Brief   : Directed self-checking bench; a CNT_W=8 and a CNT_W=2 instance
//           share the same stimulus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bitwise_reduce_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] op = 2'd0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [7:0] out_data_a, out_data_b;
    logic [7:0] out_count_a;
    logic [1:0] out_count_b;
    logic       out_parity_a, out_parity_b;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    bitwise_reduce_unit #(.WIDTH(8), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .op(op),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_count(out_count_a)
`ifdef LOGIC_REDUCE_PARITY_EN
        , .out_parity(out_parity_a)
`endif
    );

    bitwise_reduce_unit #(.WIDTH(8), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .op(op),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_count(out_count_b)
`ifdef LOGIC_REDUCE_PARITY_EN
        , .out_parity(out_parity_b)
`endif
    );

`ifndef LOGIC_REDUCE_PARITY_EN
    assign out_parity_a = 1'b0;
    assign out_parity_b = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends n beats (first beat in the low byte of w); op is switched to o2
    // after the first beat, then holds the result for stall cycles.
    task automatic run_pkt(input string tag, input logic [1:0] o, input logic [1:0] o2,
                           input int n, input logic [63:0] w, input logic [7:0] exp_d,
                           input int stall);
        int exp_cb;
        exp_cb = (n > 3) ? 3 : n;
        op = o;
        for (int i = 0; i < n; i++) begin
            check({tag, " in_ready"}, {31'b0, in_ready_a}, 32'd1);
            in_valid = 1'b1;
            in_data  = w[8*i +: 8];
            in_last  = (i == n - 1);
            tick();
            if (i == 0) op = o2;
            check({tag, " out_valid"}, {31'b0, out_valid_a}, (i == n - 1) ? 32'd1 : 32'd0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check({tag, " data"},    {24'b0, out_data_a},  {24'b0, exp_d});
        check({tag, " count"},   {24'b0, out_count_a}, n);
        check({tag, " data_b"},  {24'b0, out_data_b},  {24'b0, exp_d});
        check({tag, " count_b"}, {30'b0, out_count_b}, exp_cb);
        check({tag, " hold_rdy"}, {31'b0, in_ready_a}, 32'd0);
`ifdef LOGIC_REDUCE_PARITY_EN
        check({tag, " parity"}, {31'b0, out_parity_a}, {31'b0, ^exp_d});
`endif
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            in_data  = 8'hEE;
            in_last  = 1'b1;
            tick();
            check({tag, " stall_valid"}, {31'b0, out_valid_a}, 32'd1);
            check({tag, " stall_data"},  {24'b0, out_data_a},  {24'b0, exp_d});
            check({tag, " stall_count"}, {24'b0, out_count_a}, n);
            check({tag, " stall_rdy"},   {31'b0, in_ready_a},  32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        check({tag, " done_valid"}, {31'b0, out_valid_a}, 32'd0);
        check({tag, " done_rdy"},   {31'b0, in_ready_a},  32'd1);
    endtask

    initial begin
        #1;
        tick();
        check("rst in_ready",  {31'b0, in_ready_a},  32'd0);
        check("rst out_valid", {31'b0, out_valid_a}, 32'd0);
        check("rst out_data",  {24'b0, out_data_a},  32'd0);
        check("rst out_count", {24'b0, out_count_a}, 32'd0);
        check("rst parity",    {31'b0, out_parity_a}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst in_ready", {31'b0, in_ready_a}, 32'd1);

        // AND with op switched to OR after first beat: OR would give 0xFF.
        run_pkt("and",   2'd0, 2'd1, 3, 64'h3C_F0_FF,       8'h30, 0);
        run_pkt("xor",   2'd2, 2'd1, 4, 64'h08_04_02_01,    8'h0F, 0);
        run_pkt("nand1", 2'd3, 2'd3, 1, 64'hA5,             8'h5A, 0);
        run_pkt("or0",   2'd1, 2'd1, 2, 64'h00_00,          8'h00, 5);
        // Follows directly after the handshake: first beat must be taken at once.
        run_pkt("or6",   2'd1, 2'd0, 6, 64'h20_10_08_04_02_01, 8'h3F, 0);
        run_pkt("nand3", 2'd3, 2'd0, 3, 64'hFF_0F_3F,       8'hF0, 0);

        // Reset in the middle of a 4-beat packet.
        op = 2'd1;
        in_valid = 1'b1;
        in_last  = 1'b0;
        in_data  = 8'hAA;
        tick();
        in_data  = 8'h55;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst in_ready",  {31'b0, in_ready_a},  32'd0);
        check("mid_rst out_valid", {31'b0, out_valid_a}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst after valid", {31'b0, out_valid_a}, 32'd0);
        run_pkt("fresh", 2'd0, 2'd0, 1, 64'h11, 8'h11, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
